// File: rtl/skein_pkg.sv
// Shared Skein constants: key geometry and the built-in default key,
// plus helpers that size the key loader from those constants.
package skein_pkg;

  localparam int SKEIN_KEY_W  = 1024;
  localparam int SKEIN_WORD_W = 64;

  // Word 0 is the rightmost term, so it lands in key bits [63:0].
  localparam logic [SKEIN_KEY_W-1:0] SKEIN_DEFAULT_KEY = {
    64'h1DE0536E8682E539, 64'h61FD3062D00A579A,
    64'h6572DD22F2B4969A, 64'h0996753C10ED0BB8,
    64'h1A1F1DDE743F02D4, 64'h9243C60DCCFF1332,
    64'h6A9B0BFC6EB67E0D, 64'hD6D14AF9C6329AB5,
    64'hC11E1DB524DCB0A3, 64'h77E2BDFDC6394ADA,
    64'h6E510B8BCDD0589F, 64'h1CAEC6FD1983A898,
    64'h03BD41D3FCBCAFAF, 64'h5180E5AEBAF2C4F0,
    64'h15B5E511AC73E00C, 64'hD593DA0741E72355
  };

  function automatic int calc_nwords(input int key_w, input int word_w);
    return key_w / word_w;
  endfunction

  function automatic int idx_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/key_word_counter.sv
// Saturating 0..NWORDS word counter with clear; reports full and the
// shadow word index that the next accepted word will be written to.
module key_word_counter
  import skein_pkg::*;
#(
  parameter int NWORDS = 16,
  parameter int CW     = $clog2(NWORDS + 1),
  parameter int IW     = idx_width(NWORDS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic [IW-1:0] idx_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(NWORDS);

  logic [CW-1:0] count_q, count_d;

  // NOTE: default-first assignment keeps this block free of inferred latches.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != FULL_CNT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == FULL_CNT);
  assign idx_o   = count_q[IW-1:0];

endmodule

// File: rtl/key_loader.sv
// Run-time loadable Skein key: words stream into a shadow register and
// the whole shadow is committed atomically to the active key register.
module key_loader
  import skein_pkg::*;
#(
  parameter int                KEY_W       = SKEIN_KEY_W,
  parameter int                WORD_W      = SKEIN_WORD_W,
  parameter logic [KEY_W-1:0]  DEFAULT_KEY = SKEIN_DEFAULT_KEY,
  localparam int               NWORDS      = calc_nwords(KEY_W, WORD_W),
  localparam int               CW          = $clog2(NWORDS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  input  logic              commit_i,
  input  logic              abort_i,
  input  logic              restore_i,
  output logic [KEY_W-1:0]  key_o,
  output logic              key_update_o,
  output logic [CW-1:0]     count_o,
  output logic              commit_err_o
);

  localparam int IW = idx_width(NWORDS);

  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic             key_update_q, key_update_d;
  logic             commit_err_q, commit_err_d;

  logic          full;
  logic [IW-1:0] idx;
  logic          clr;
  logic          accept;

  key_word_counter #(
    .NWORDS (NWORDS),
    .CW     (CW),
    .IW     (IW)
  ) u_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr),
    .inc_i   (accept),
    .count_o (count_o),
    .full_o  (full),
    .idx_o   (idx)
  );

  // Priority restore > abort > commit > word; a failed commit still lets
  // a same-cycle word in, so committing with the last word is an error.
  always_comb begin
    key_d        = key_q;
    shadow_d     = shadow_q;
    key_update_d = 1'b0;
    commit_err_d = 1'b0;
    clr          = 1'b0;
    accept       = 1'b0;
    if (restore_i) begin
      key_d        = DEFAULT_KEY;
      key_update_d = 1'b1;
      clr          = 1'b1;
    end else if (abort_i) begin
      clr = 1'b1;
    end else if (commit_i && full) begin
      key_d        = shadow_q;
      key_update_d = 1'b1;
      clr          = 1'b1;
    end else begin
      commit_err_d = commit_i;
      accept       = word_valid_i && !full;
    end
    for (int w = 0; w < NWORDS; w++) begin
      if (accept && (idx == IW'(w))) begin
        shadow_d[w*WORD_W +: WORD_W] = word_i;
      end
    end
  end

  // NOTE: the wide shadow register is reset too, so a fresh load never
  // exposes stale key material from before the reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_q        <= DEFAULT_KEY;
      shadow_q     <= '0;
      key_update_q <= 1'b0;
      commit_err_q <= 1'b0;
    end else begin
      key_q        <= key_d;
      shadow_q     <= shadow_d;
      key_update_q <= key_update_d;
      commit_err_q <= commit_err_d;
    end
  end

  assign word_ready_o = !full;
  assign key_o        = key_q;
  assign key_update_o = key_update_q;
  assign commit_err_o = commit_err_q;

endmodule

// File: tb/tb_key_loader.sv
// Directed-plus-random bench for key_loader against a queue-based model
// of the shadow load, commit, abort and restore rules.
module tb_key_loader;
  import skein_pkg::*;

  localparam int KW = 1024;
  localparam int WW = 64;
  localparam int NW = 16;
  localparam int CW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [WW-1:0] word_i;
  logic          word_valid_i;
  logic          word_ready_o;
  logic          commit_i;
  logic          abort_i;
  logic          restore_i;
  logic [KW-1:0] key_o;
  logic          key_update_o;
  logic [CW-1:0] count_o;
  logic          commit_err_o;

  key_loader #(.KEY_W(KW), .WORD_W(WW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .commit_i     (commit_i),
    .abort_i      (abort_i),
    .restore_i    (restore_i),
    .key_o        (key_o),
    .key_update_o (key_update_o),
    .count_o      (count_o),
    .commit_err_o (commit_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference state: shadow as a queue of accepted words, active key, pulses.
  logic [WW-1:0] m_q[$];
  logic [KW-1:0] m_key;
  logic          m_upd;
  logic          m_err;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_key(input string tag, input logic [KW-1:0] exp);
    for (int k = 0; k < NW; k++) begin
      check($sformatf("%s_w%0d", tag, k), key_o[k*WW +: WW], exp[k*WW +: WW]);
    end
  endtask

  function automatic logic [KW-1:0] pack_shadow();
    logic [KW-1:0] v = '0;
    for (int k = 0; k < m_q.size(); k++) v[k*WW +: WW] = m_q[k];
    return v;
  endfunction

  task automatic tick();
    m_upd = 1'b0;
    m_err = 1'b0;
    if (rst_i) begin
      m_key = SKEIN_DEFAULT_KEY;
      m_q.delete();
    end else if (restore_i) begin
      m_key = SKEIN_DEFAULT_KEY;
      m_q.delete();
      m_upd = 1'b1;
    end else if (abort_i) begin
      m_q.delete();
    end else if (commit_i && m_q.size() == NW) begin
      m_key = pack_shadow();
      m_q.delete();
      m_upd = 1'b1;
    end else begin
      m_err = commit_i;
      if (word_valid_i && m_q.size() < NW) m_q.push_back(word_i);
    end
    @(posedge clk_i);
    #1;
    check_key("key", m_key);
    check("count", WW'(count_o), WW'(m_q.size()));
    check("ready", WW'(word_ready_o), WW'(m_q.size() != NW));
    check("key_update", WW'(key_update_o), WW'(m_upd));
    check("commit_err", WW'(commit_err_o), WW'(m_err));
  endtask

  task automatic drive(input bit v, input logic [WW-1:0] w, input bit c,
                       input bit a, input bit r, input bit rs);
    word_valid_i = v;
    word_i       = w;
    commit_i     = c;
    abort_i      = a;
    restore_i    = r;
    rst_i        = rs;
    tick();
  endtask

  function automatic logic [WW-1:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    word_i = '0; word_valid_i = 1'b0; commit_i = 1'b0;
    abort_i = 1'b0; restore_i = 1'b0; rst_i = 1'b1;

    // Reset then idle: default key, empty shadow, no pulses.
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, rnd_word(), 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) idle();
    check_key("reset_key", SKEIN_DEFAULT_KEY);
    check("reset_ready", WW'(word_ready_o), 64'd1);

    // Ascending pattern load and commit.
    for (int i = 0; i < NW; i++) drive(1'b1, WW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_count", WW'(count_o), 64'd16);
    check("full_ready", WW'(word_ready_o), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < NW; k++) check($sformatf("pattern_w%0d", k), key_o[k*WW +: WW], WW'(k));
    check("pattern_update", WW'(key_update_o), 64'd1);
    idle();
    check("pattern_update_drop", WW'(key_update_o), 64'd0);

    // Early commit is rejected, abort clears, full reload commits.
    load_random(10);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("early_err", WW'(commit_err_o), 64'd1);
    check("early_count", WW'(count_o), 64'd10);
    idle();
    drive(1'b1, rnd_word(), 1'b1, 1'b1, 1'b0, 1'b0);
    check("abort_count", WW'(count_o), 64'd0);
    load_random(NW);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Full shadow holds off valid words; restore beats commit.
    load_random(NW);
    for (int i = 0; i < 3; i++) drive(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, rnd_word(), 1'b1, 1'b0, 1'b1, 1'b0);
    check_key("restore_key", SKEIN_DEFAULT_KEY);
    check("restore_update", WW'(key_update_o), 64'd1);
    idle();

    // Reset mid-load, then a clean load from word 0.
    load_random(NW);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    load_random(7);
    drive(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_count", WW'(count_o), 64'd0);
    check_key("midrst_key", SKEIN_DEFAULT_KEY);
    for (int i = 0; i < NW; i++) drive(1'b1, WW'(64'hA5 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reload_w0", key_o[WW-1:0], 64'hA5);
    check("reload_w15", key_o[KW-1 -: WW], 64'hB4);

    // Commit coincident with the last word is an error; next commit works.
    load_random(NW - 1);
    drive(1'b1, rnd_word(), 1'b1, 1'b0, 1'b0, 1'b0);
    check("last_word_err", WW'(commit_err_o), 64'd1);
    check("last_word_count", WW'(count_o), 64'd16);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("last_word_update", WW'(key_update_o), 64'd1);

    // Random traffic, including back-to-back commits and rare resets.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, rnd_word(),
            $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 47) == 0, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
